pipeline_stall_controller: RTL and testbench

Central hazard sequencer for the 5-stage MIPS pipeline. It combines four stall and flush sources into one set of stage-enable and flush controls:
- load-use data hazard
- conditional branch resolution window
- jump squash
- multi-cycle mult/div occupancy

It sits beside the ID stage, drives the PC, IF/ID and ID/EX registers, and arbitrates between simultaneous hazard sources with a fixed priority.

---
 rtl/pipeline_pkg.sv | 70 +++++++
 rtl/pipeline_stall_controller_muldiv.sv | 39 +++
 rtl/pipeline_stall_controller.sv | 200 ++++++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared opcode/funct constants, branch FSM state encoding and instruction
// class decoders for the 5-stage MIPS pipeline hazard logic.
package pipeline_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;

    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MFLO   = 6'h12;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BR_WAIT1 = 2'd1,
        BR_WAIT2 = 2'd2
    } br_state_e;

    // Which priority row drives the controls in the current cycle.
    typedef enum logic [2:0] {
        ROW_NONE = 3'd0,
        ROW_BR1  = 3'd1,
        ROW_BR2  = 3'd2,
        ROW_MD   = 3'd3,
        ROW_LU   = 3'd4,
        ROW_JUMP = 3'd5
    } hz_row_e;

    function automatic logic is_branch(input logic [5:0] op);
        logic r;
        case (op)
            OP_BEQ, OP_BNE: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        logic r;
        case (op)
            OP_J, OP_JAL: r = 1'b1;
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] funct);
        logic r;
        case (funct)
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: r = (op == OP_RTYPE);
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_hilo_read(input logic [5:0] op, input logic [5:0] funct);
        logic r;
        case (funct)
            FN_MFHI, FN_MFLO: r = (op == OP_RTYPE);
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_muldiv.sv
// Tracks how long the HI/LO unit stays occupied after a mult/div issues.
module muldiv_busy_tracker #(
    parameter int MD_LATENCY = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic issue_i,
    output logic busy_o
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    logic [3:0] md_cnt_q;
    logic [3:0] md_cnt_d;

    // Reload on issue, otherwise count down to zero.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (issue_i) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            md_cnt_q <= 4'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign busy_o = (md_cnt_q != 4'd0);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Fixed-priority hazard sequencer: load-use, branch window, jump squash and
// mult/div occupancy. Optional perf counters under STALL_PERF_CNT_EN.
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [5:0]       ID_Op,
    input  logic [5:0]       ID_Funct,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             BranchResolve,
    output logic             Stall
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] PerfLU,
    output logic [CNT_W-1:0] PerfBR,
    output logic [CNT_W-1:0] PerfMD,
    output logic [CNT_W-1:0] PerfJ
`endif
);

    br_state_e state_q;
    br_state_e state_d;
    hz_row_e   row_s;

    logic is_br_s;
    logic is_j_s;
    logic is_md_s;
    logic is_hilo_s;
    logic lu_s;
    logic md_busy_s;
    logic md_haz_s;
    logic md_issue_s;

    assign is_br_s   = is_branch(ID_Op);
    assign is_j_s    = is_jump(ID_Op);
    assign is_md_s   = is_muldiv(ID_Op, ID_Funct);
    assign is_hilo_s = is_hilo_read(ID_Op, ID_Funct);

    assign lu_s = EX_MemRead && (EX_Rt != 5'd0) &&
                  ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    assign md_haz_s = md_busy_s && (is_hilo_s || is_md_s);

    // A mult/div only claims the unit once it actually leaves ID.
    assign md_issue_s = !Reset && is_md_s && (row_s == ROW_NONE);

    muldiv_busy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .issue_i (md_issue_s),
        .busy_o  (md_busy_s)
    );

    // Pick the highest-priority active hazard row.
    always_comb begin
        row_s = ROW_NONE;
        if (Reset) begin
            row_s = ROW_NONE;
        end else if (state_q == BR_WAIT1) begin
            row_s = ROW_BR1;
        end else if (state_q == BR_WAIT2) begin
            row_s = ROW_BR2;
        end else if (md_haz_s) begin
            row_s = ROW_MD;
        end else if (lu_s) begin
            row_s = ROW_LU;
        end else if ((state_q == IDLE) && is_j_s) begin
            row_s = ROW_JUMP;
        end else begin
            row_s = ROW_NONE;
        end
    end

    // Stage-enable and flush controls for the selected row.
    always_comb begin
        PC_Write      = 1'b1;
        IFID_Write    = 1'b1;
        IFID_Flush    = 1'b0;
        IDEX_Bubble   = 1'b0;
        BranchResolve = 1'b0;
        Stall         = 1'b0;
        case (row_s)
            ROW_BR1: begin
                PC_Write   = 1'b0;
                IFID_Flush = 1'b1;
                Stall      = 1'b1;
            end
            ROW_BR2: begin
                BranchResolve = 1'b1;
                IFID_Flush    = 1'b1;
                Stall         = 1'b1;
            end
            ROW_MD, ROW_LU: begin
                PC_Write    = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
                Stall       = 1'b1;
            end
            ROW_JUMP: begin
                IFID_Flush = 1'b1;
            end
            default: begin
                PC_Write = 1'b1;
            end
        endcase
    end

    // Branch window sequencing; a stalled branch waits in ID and retries.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_br_s && !md_haz_s && !lu_s) begin
                    state_d = BR_WAIT1;
                end else begin
                    state_d = IDLE;
                end
            end
            BR_WAIT1: state_d = BR_WAIT2;
            BR_WAIT2: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Branch FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_q, perf_lu_d;
    logic [CNT_W-1:0] perf_br_q, perf_br_d;
    logic [CNT_W-1:0] perf_md_q, perf_md_d;
    logic [CNT_W-1:0] perf_j_q,  perf_j_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Bump the counter belonging to the applied row.
    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_br_d = perf_br_q;
        perf_md_d = perf_md_q;
        perf_j_d  = perf_j_q;
        case (row_s)
            ROW_LU:           perf_lu_d = sat_inc(perf_lu_q);
            ROW_BR1, ROW_BR2: perf_br_d = sat_inc(perf_br_q);
            ROW_MD:           perf_md_d = sat_inc(perf_md_q);
            ROW_JUMP:         perf_j_d  = sat_inc(perf_j_q);
            default:          perf_lu_d = perf_lu_q;
        endcase
    end

    // Performance counter registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            perf_lu_q <= {CNT_W{1'b0}};
            perf_br_q <= {CNT_W{1'b0}};
            perf_md_q <= {CNT_W{1'b0}};
            perf_j_q  <= {CNT_W{1'b0}};
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_br_q <= perf_br_d;
            perf_md_q <= perf_md_d;
            perf_j_q  <= perf_j_d;
        end
    end

    assign PerfLU = perf_lu_q;
    assign PerfBR = perf_br_q;
    assign PerfMD = perf_md_q;
    assign PerfJ  = perf_j_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector bench for pipeline_stall_controller; expected control words
// are hand-derived constants {PC_Write,IFID_Write,IFID_Flush,IDEX_Bubble,BranchResolve,Stall}.
module tb_pipeline_stall_controller;

    localparam logic [5:0] C_NORM = 6'b110000;
    localparam logic [5:0] C_BR1  = 6'b011001;
    localparam logic [5:0] C_BR2  = 6'b111011;
    localparam logic [5:0] C_HAZ  = 6'b000101;
    localparam logic [5:0] C_JMP  = 6'b111000;

    localparam logic [5:0] OPR  = 6'd0;
    localparam logic [5:0] OBEQ = 6'd4;
    localparam logic [5:0] OJ   = 6'd2;
    localparam logic [5:0] OJAL = 6'd3;
    localparam logic [5:0] FADD = 6'h20;
    localparam logic [5:0] FMLT = 6'h18;
    localparam logic [5:0] FDIV = 6'h1A;
    localparam logic [5:0] FMFH = 6'h10;
    localparam logic [5:0] FMFL = 6'h12;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] ID_Op = 6'd0;
    logic [5:0] ID_Funct = 6'd0;
    logic [4:0] ID_Rs = 5'd0;
    logic [4:0] ID_Rt = 5'd0;
    logic       ID_UsesRt = 1'b0;
    logic       EX_MemRead = 1'b0;
    logic [4:0] EX_Rt = 5'd0;
    logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, BranchResolve, Stall;
    logic [5:0] ctl;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] PerfLU, PerfBR, PerfMD, PerfJ;
`endif

    int n_vec = 0;
    int n_err = 0;

    assign ctl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, BranchResolve, Stall};

    always #5 Clock = ~Clock;

    pipeline_stall_controller #(
        .MD_LATENCY (4),
        .CNT_W      (32)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .ID_Op         (ID_Op),
        .ID_Funct      (ID_Funct),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_UsesRt     (ID_UsesRt),
        .EX_MemRead    (EX_MemRead),
        .EX_Rt         (EX_Rt),
        .PC_Write      (PC_Write),
        .IFID_Write    (IFID_Write),
        .IFID_Flush    (IFID_Flush),
        .IDEX_Bubble   (IDEX_Bubble),
        .BranchResolve (BranchResolve),
        .Stall         (Stall)
`ifdef STALL_PERF_CNT_EN
        ,
        .PerfLU        (PerfLU),
        .PerfBR        (PerfBR),
        .PerfMD        (PerfMD),
        .PerfJ         (PerfJ)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID/EX vector, check controls mid-cycle, then advance a clock.
    task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                       input logic mr, input logic [4:0] ert, input logic [5:0] exp);
        ID_Op = op; ID_Funct = fn; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = ut;
        EX_MemRead = mr; EX_Rt = ert;
        @(negedge Clock);
        check_eq(tag, {26'd0, ctl}, {26'd0, exp});
        @(posedge Clock);
        #1;
    endtask

    task automatic nop(input string tag, input logic [5:0] exp);
        cyc(tag, OPR, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge Clock); #1;
        nop("rst_a", C_NORM);
        nop("rst_b", C_NORM);
        Reset = 1'b0;

        // Reset during branch window and during mult/div occupancy.
        cyc("t1_beq", OBEQ, 6'd0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, C_NORM);
        nop("t1_w1", C_BR1);
        Reset = 1'b1;
        nop("t1_rst0", C_NORM);
        nop("t1_rst1", C_NORM);
        Reset = 1'b0;
        nop("t1_rel", C_NORM);
        nop("t1_rel2", C_NORM);
        cyc("t1_mult", OPR, FMLT, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, C_NORM);
        Reset = 1'b1;
        nop("t1_mdrst", C_NORM);
        Reset = 1'b0;
        cyc("t1_mflo", OPR, FMFL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_NORM);

        // Load-use on rs, rt, and the $zero / unused-rt exclusions.
        cyc("t2_lu_rs", OPR, FADD, 5'd8, 5'd3, 1'b1, 1'b1, 5'd8, C_HAZ);
        cyc("t2_after", OPR, FADD, 5'd8, 5'd3, 1'b1, 1'b0, 5'd0, C_NORM);
        cyc("t2_zero", OPR, FADD, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, C_NORM);
        cyc("t2_lu_rt", OPR, FADD, 5'd1, 5'd9, 1'b1, 1'b1, 5'd9, C_HAZ);
        cyc("t2_nort", OPR, FADD, 5'd1, 5'd9, 1'b0, 1'b1, 5'd9, C_NORM);

        // Branch window with a branch and a jump in its shadow.
        cyc("t3_beq", OBEQ, 6'd0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, C_NORM);
        cyc("t3_w1", OBEQ, 6'd0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, C_BR1);
        cyc("t3_w2", OJ, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_BR2);
        nop("t3_done", C_NORM);
        nop("t3_done2", C_NORM);

        // Load-use feeding a branch: one bubble then the 2-cycle window.
        cyc("t4_lu", OBEQ, 6'd0, 5'd8, 5'd2, 1'b1, 1'b1, 5'd8, C_HAZ);
        cyc("t4_beq", OBEQ, 6'd0, 5'd8, 5'd2, 1'b1, 1'b0, 5'd0, C_NORM);
        nop("t4_w1", C_BR1);
        nop("t4_w2", C_BR2);
        nop("t4_done", C_NORM);

        // mult then mflo: three held cycles with MD_LATENCY=4.
        cyc("t5_mult", OPR, FMLT, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, C_NORM);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("t5_hold%0d", i), OPR, FMFL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_HAZ);
        cyc("t5_go", OPR, FMFL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_NORM);
        cyc("t5_mult2", OPR, FMLT, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, C_NORM);
        cyc("t5_add", OPR, FADD, 5'd6, 5'd7, 1'b1, 1'b0, 5'd0, C_NORM);
        cyc("t5_mfhi0", OPR, FMFH, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_HAZ);
        cyc("t5_mfhi1", OPR, FMFH, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_HAZ);
        cyc("t5_mfhi2", OPR, FMFH, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_NORM);

        // Back-to-back mult/div: the second waits, then reloads the counter.
        cyc("t5_mult3", OPR, FMLT, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, C_NORM);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("t5_divw%0d", i), OPR, FDIV, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, C_HAZ);
        cyc("t5_div", OPR, FDIV, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, C_NORM);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("t5_mflow%0d", i), OPR, FMFL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_HAZ);
        cyc("t5_mflo2", OPR, FMFL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_NORM);

        // Jump squash.
        cyc("t6_j", OJ, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_JMP);
        nop("t6_after", C_NORM);
`ifdef STALL_PERF_CNT_EN
        check_eq("t6_perfj", PerfJ, 32'd1);
`endif
        cyc("t6_jal", OJAL, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, C_JMP);
        nop("t6_end", C_NORM);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
